// File: rtl/uart_word_loader_if.sv
// Bus between uart_word_loader and its UART pair and mem_single.
// The master side is the loader itself.
interface uart_word_loader_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  logic [7:0]       rx_data;
  logic             rx_done;
  logic [DEPTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_data;
  logic             mem_wr_en;
  logic [WIDTH-1:0] mem_q;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_done;
  logic             busy;
  logic             done;

  modport master (
    input  rx_data,
    input  rx_done,
    input  mem_q,
    input  tx_done,
    output mem_address,
    output mem_data,
    output mem_wr_en,
    output tx_start,
    output tx_data,
    output busy,
    output done
  );

  modport slave (
    output rx_data,
    output rx_done,
    output mem_q,
    output tx_done,
    input  mem_address,
    input  mem_data,
    input  mem_wr_en,
    input  tx_start,
    input  tx_data,
    input  busy,
    input  done
  );
endinterface

// File: rtl/uart_word_loader.sv
// Packs UART bytes into words, writes them to mem_single,
// then reads every word back and streams it out byte by byte.
module uart_word_loader #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int N_WORDS = 8
) (
  input  logic             clk,
  input  logic             reset,
  uart_word_loader_if.master bus
);
  localparam int BYTES = WIDTH / 8;
  localparam int BCW   = $clog2(BYTES + 1);

  localparam logic [BCW-1:0] B_LAST = BCW'(BYTES - 1);
  localparam logic [DEPTH:0] W_LAST = (DEPTH+1)'(N_WORDS - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_WRITE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_SEND,
    S_WAIT_TX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DEPTH:0]   word_cnt_q, word_cnt_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LOAD;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    unique case (state_q)
      S_LOAD: begin
        if (bus.rx_done) begin
          for (int i = 0; i < BYTES; i++) begin
            if (byte_cnt_q == BCW'(i)) begin
              shreg_d[8*i +: 8] = bus.rx_data;
            end
          end
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == B_LAST) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        byte_cnt_d = '0;
        if (word_cnt_q == W_LAST) begin
          word_cnt_d = '0;
          state_d    = S_RD_ADDR;
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_RD_ADDR: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        shreg_d    = bus.mem_q;
        byte_cnt_d = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (bus.tx_done) begin
          if (byte_cnt_q == B_LAST) begin
            // park the lane index so tx_data never points past the word
            byte_cnt_d = '0;
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == W_LAST) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RD_ADDR;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = S_SEND;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_comb begin
    bus.mem_address = word_cnt_q[DEPTH-1:0];
    bus.mem_data    = shreg_q;
    bus.mem_wr_en   = (state_q == S_WRITE);
    bus.tx_start    = (state_q == S_SEND);
    bus.tx_data     = 8'h00;
    for (int i = 0; i < BYTES; i++) begin
      if (byte_cnt_q == BCW'(i)) begin
        bus.tx_data = shreg_q[8*i +: 8];
      end
    end
    bus.done = (state_q == S_DONE);
    if (state_q == S_LOAD) begin
      bus.busy = (byte_cnt_q != '0);
    end else begin
      bus.busy = (state_q != S_DONE);
    end
  end
endmodule

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
- Sits between the UART Receiver/Transmitter pair and a mem_single instance.
- Packs received bytes into WIDTH-bit words and writes them to consecutive memory addresses.
- Once N_WORDS words are stored, reads every word back and streams it byte-by-byte to the Transmitter for host-side verification of memory contents.
- Provides the address generation and write-enable sequencing that mem_single needs when loaded over UART.

Parameters:
- WIDTH, 32, memory word width in bits; must be a multiple of 8 (BYTES = WIDTH/8).
- DEPTH, 8, address width in bits.
- N_WORDS, 8, words loaded before readback; 1 <= N_WORDS <= 2^DEPTH.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- rx_data  input  8  byte from Receiver data_out
- rx_done  input  1  one-cycle strobe, rx_data valid
- mem_address  output  DEPTH  to mem_single address
- mem_data  output  WIDTH  to mem_single data
- mem_wr_en  output  1  to mem_single wr_en, one-cycle pulse
- mem_q  input  WIDTH  from mem_single q; synchronous read, valid the cycle after mem_address is registered
- tx_start  output  1  one-cycle pulse to Transmitter
- tx_data  output  8  byte to Transmitter data_in, held stable from tx_start until tx_done
- tx_done  input  1  one-cycle strobe from Transmitter, byte finished
- busy  output  1  high in LOAD-with-partial-word, WRITE, RD_ADDR, RD_WAIT, SEND, WAIT_TX
- done  output  1  high in DONE state

Behaviour:
- Reset (synchronous, active-high) clears all outputs to 0, word_cnt, byte_cnt and shift register to 0, and sets state to LOAD. Reset in any state aborts immediately; no pending write or tx_start is issued.
- Byte packing is little-endian: the first byte of a word goes to bits [7:0], the k-th byte to bits [8k+7:8k].
- LOAD:
  - On rx_done, store rx_data in lane byte_cnt and increment byte_cnt.
  - On the byte that makes byte_cnt reach BYTES, go to WRITE.
- WRITE (1 cycle):
  - mem_wr_en=1, mem_data=packed word, mem_address=word_cnt.
  - Next cycle: byte_cnt=0, word_cnt+1. Go to LOAD if word_cnt+1 < N_WORDS, else RD_ADDR with word_cnt=0.
  - Write latency: last byte's rx_done at cycle t gives mem_wr_en at t+1.
- RD_ADDR: mem_address=word_cnt, mem_wr_en=0. Go to RD_WAIT.
- RD_WAIT: capture mem_q into the read shift register, byte_cnt=0. Go to SEND.
- SEND (1 cycle): tx_start=1, tx_data=lane byte_cnt. Go to WAIT_TX.
- WAIT_TX: wait for tx_done, then increment byte_cnt.
  - If more bytes remain in the word, go to SEND.
  - Else increment word_cnt; go to RD_ADDR if word_cnt < N_WORDS, else DONE.
- DONE: done=1, busy=0. Hold until reset.
- rx_done outside LOAD is ignored: no lane write, no counter change.
- rx_done in the WRITE cycle is also ignored. The Receiver's frame spacing guarantees it cannot occur there.
- tx_done outside WAIT_TX is ignored.
- Counter widths:
  - word_cnt: DEPTH+1 bits, so N_WORDS = 2^DEPTH does not wrap before the compare.
  - mem_address: the low DEPTH bits of word_cnt.
- No bytes are dropped within LOAD; no flow control toward the Receiver exists.

Test Plan:
- Reset then 32 bytes 0x00..0x1F via rx_done (WIDTH=32, N_WORDS=8) -> 8 mem_wr_en pulses at addresses 0..7. Address 0 data 0x03020100; address 7 data 0x1F1E1D1C. Each pulse is exactly 1 cycle after the 4th byte's rx_done.
- Continue with a tx_done model returning 20 cycles after each tx_start -> 32 tx_start pulses with tx_data 0x00..0x1F in order, then done=1, busy=0. tx_data is stable between each tx_start and its tx_done.
- Assert reset after 2 of 4 bytes, then send 0xAA,0xBB,0xCC,0xDD -> first write is address 0 with data 0xDDCCBBAA; the partial bytes are discarded.
- Pulse rx_done with 0x55 during WAIT_TX and again in DONE -> no mem_wr_en, transmitted stream unchanged, done stays 1.
- Assert reset in WAIT_TX with tx_done pending -> tx_start stays 0, state LOAD, mem_address=0, busy=0 the cycle after reset.
- Pulse tx_done spuriously in LOAD -> no state or counter change.
